// File: rtl/pipelined_carry_skip_adder_if.sv
// Stream bundle for pipelined_carry_skip_adder.
// Request side: valid_i/ready_o, operands, carry_i, sub_i.
// Response side: valid_o/ready_i, result_o, carry_o, overflow_o.
interface pipelined_carry_skip_adder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] operand_A_i;
    logic [DATA_WIDTH-1:0] operand_B_i;
    logic                  carry_i;
    logic                  sub_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] result_o;
    logic                  carry_o;
    logic                  overflow_o;

    modport slave (
        input  valid_i, operand_A_i, operand_B_i,
        input  carry_i, sub_i, ready_i,
        output ready_o, valid_o, result_o,
        output carry_o, overflow_o
    );

    modport master (
        output valid_i, operand_A_i, operand_B_i,
        output carry_i, sub_i, ready_i,
        input  ready_o, valid_o, result_o,
        input  carry_o, overflow_o
    );
endinterface

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor, STAGES slices.
// Ports: clk_i, rst_n_i (async low), bus (stream slave).
module pipelined_carry_skip_adder #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 4,
    parameter int STAGES      = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    pipelined_carry_skip_adder_if.slave bus
);
    localparam int W  = DATA_WIDTH / STAGES;
    localparam int NB = W / BLOCK_WIDTH;

    // Returns {carry into slice MSB, slice carry-out, sum}.
    function automatic logic [W+1:0] skip_slice(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         cin
    );
        logic [W-1:0] s;
        logic c, rc, bp, cm, p;
        int n;
        s  = '0;
        c  = cin;
        cm = cin;
        for (int j = 0; j < NB; j++) begin
            rc = c;
            bp = 1'b1;
            for (int i = 0; i < BLOCK_WIDTH; i++) begin
                n    = j * BLOCK_WIDTH + i;
                p    = a[n] ^ b[n];
                s[n] = p ^ rc;
                cm   = rc;
                rc   = (a[n] & b[n]) | (p & rc);
                bp   = bp & p;
            end
            // skip mux: a fully propagating block passes its carry-in
            c = bp ? c : rc;
        end
        return {cm, c, s};
    endfunction

    logic [DATA_WIDTH-1:0] a_q [STAGES];
    logic [DATA_WIDTH-1:0] b_q [STAGES];
    logic [DATA_WIDTH-1:0] r_q [STAGES];
    logic [STAGES-1:0]     v_q;
    logic [STAGES-1:0]     c_q;
    logic                  o_q;

    logic [DATA_WIDTH-1:0] a_d [STAGES];
    logic [DATA_WIDTH-1:0] b_d [STAGES];
    logic [DATA_WIDTH-1:0] r_d [STAGES];
    logic [STAGES-1:0]     v_d;
    logic [STAGES-1:0]     c_d;
    logic                  o_d;
    logic [STAGES-1:0]     load;

    // Stage k slices bits [k*W +: W] of what stage k-1 holds;
    // stage 0 works straight from the (B-conditioned) inputs.
    always_comb begin
        logic [DATA_WIDTH-1:0] pa, pb, pr;
        logic                  pc, pv;
        logic [W+1:0]          sl;
        pa  = bus.operand_A_i;
        pb  = bus.operand_B_i ^ {DATA_WIDTH{bus.sub_i}};
        pr  = '0;
        pc  = bus.carry_i;
        pv  = bus.valid_i;
        sl  = '0;
        o_d = 1'b0;
        v_d = '0;
        c_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl   = skip_slice(pa[k*W +: W], pb[k*W +: W], pc);
            a_d[k] = pa;
            b_d[k] = pb;
            r_d[k] = pr;
            r_d[k][k*W +: W] = sl[W-1:0];
            c_d[k] = sl[W];
            v_d[k] = pv;
            o_d  = sl[W+1] ^ sl[W];
            pa   = a_q[k];
            pb   = b_q[k];
            pr   = r_q[k];
            pc   = c_q[k];
            pv   = v_q[k];
        end
    end

    // A stage loads when it is empty, its successor is empty,
    // or its successor loads; the last stage when output drains.
    always_comb begin
        logic adv;
        adv = bus.ready_i | ~v_q[STAGES-1];
        load = '0;
        load[STAGES-1] = adv;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv = adv | ~v_q[k] | ~v_q[k+1];
            load[k] = adv;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v_q <= '0;
            c_q <= '0;
            o_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= v_d[k];
                    c_q[k] <= c_d[k];
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    r_q[k] <= r_d[k];
                end
            end
            if (load[STAGES-1]) begin
                o_q <= o_d;
            end
        end
    end

    assign bus.ready_o    = load[0];
    assign bus.valid_o    = v_q[STAGES-1];
    assign bus.result_o   = r_q[STAGES-1];
    assign bus.carry_o    = c_q[STAGES-1];
    assign bus.overflow_o = o_q;
endmodule
